// File: rtl/warp_regfile_param_if.sv
// Issue/writeback-side bundle for the parametrised warp register file.
// The pipeline (master) drives reads, writes and clear requests; the register file (slave) returns read data and busy.
interface warp_regfile_param_if #(
    parameter int LANES  = 16,
    parameter int WARPS  = 8,
    parameter int REGS   = 32,
    parameter int DATA_W = 64
);
    localparam int AW = $clog2(REGS);
    localparam int WW = $clog2(WARPS);

    logic [LANES-1:0]        read_en_0;
    logic [AW-1:0]           raddr_0;
    logic [LANES-1:0]        read_en_1;
    logic [AW-1:0]           raddr_1;
    logic [WW-1:0]           rwarp;
    logic [LANES-1:0]        write_en;
    logic [AW-1:0]           waddr;
    logic [WW-1:0]           wwarp;
    logic [LANES*DATA_W-1:0] wdata;
    logic                    clear_req;
    logic [WW-1:0]           clear_warp;
    logic                    busy;
    logic [LANES*DATA_W-1:0] rdata_0;
    logic                    rvalid_0;
    logic [LANES*DATA_W-1:0] rdata_1;
    logic                    rvalid_1;

    modport master (
        output read_en_0, raddr_0, read_en_1, raddr_1, rwarp,
        output write_en, waddr, wwarp, wdata, clear_req, clear_warp,
        input  busy, rdata_0, rvalid_0, rdata_1, rvalid_1
    );

    modport slave (
        input  read_en_0, raddr_0, read_en_1, raddr_1, rwarp,
        input  write_en, waddr, wwarp, wdata, clear_req, clear_warp,
        output busy, rdata_0, rvalid_0, rdata_1, rvalid_1
    );
endinterface

// File: rtl/warp_regfile_param.sv
// Per-warp, per-lane register file: two registered read ports with write-first forwarding,
// one lane-masked write port, and a sweep engine that zeroes storage after reset or per warp on request.
module warp_regfile_param #(
    parameter int LANES  = 16,
    parameter int WARPS  = 8,
    parameter int REGS   = 32,
    parameter int DATA_W = 64
) (
    input logic                clk,
    input logic                rst_n,
    warp_regfile_param_if.slave bus
);
    localparam int AW   = $clog2(REGS);
    localparam int WW   = $clog2(WARPS);
    localparam int ROWS = WARPS * REGS;
    localparam int CW   = $clog2(ROWS);

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [WW-1:0]   clear_warp_reg;
    logic            rvalid_0_reg;
    logic            rvalid_1_reg;
    logic            busy;
    logic [CW-1:0]   sweep_row;
    logic [CW-1:0]   wr_row;
    logic [CW-1:0]   rd_row_0;
    logic [CW-1:0]   rd_row_1;
    logic            hit_0;
    logic            hit_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= INIT;
            count_reg      <= '0;
            clear_warp_reg <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    if (count_reg == CW'(ROWS - 1)) state_reg <= IDLE;
                    else                            count_reg <= count_reg + 1'b1;
                end
                IDLE: begin
                    if (bus.clear_req) begin
                        state_reg      <= CLEAR;
                        count_reg      <= '0;
                        clear_warp_reg <= bus.clear_warp;
                    end
                end
                CLEAR: begin
                    if (count_reg == CW'(REGS - 1)) state_reg <= IDLE;
                    else                            count_reg <= count_reg + 1'b1;
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign bus.busy = busy;

    // Row index is {warp, register}; CLEAR only walks the register half within the latched warp.
    assign sweep_row = (state_reg == CLEAR) ? {clear_warp_reg, count_reg[AW-1:0]} : count_reg;
    assign wr_row    = busy ? sweep_row : {bus.wwarp, bus.waddr};
    assign rd_row_0  = {bus.rwarp, bus.raddr_0};
    assign rd_row_1  = {bus.rwarp, bus.raddr_1};
    assign hit_0     = (bus.wwarp == bus.rwarp) && (bus.waddr == bus.raddr_0);
    assign hit_1     = (bus.wwarp == bus.rwarp) && (bus.waddr == bus.raddr_1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_0_reg <= 1'b0;
            rvalid_1_reg <= 1'b0;
        end else begin
            rvalid_0_reg <= !busy && (|bus.read_en_0);
            rvalid_1_reg <= !busy && (|bus.read_en_1);
        end
    end

    assign bus.rvalid_0 = rvalid_0_reg;
    assign bus.rvalid_1 = rvalid_1_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] wlane;
        logic [DATA_W-1:0] rdata_0_reg;
        logic [DATA_W-1:0] rdata_1_reg;
        logic              we;

        assign wlane = bus.wdata[gi*DATA_W +: DATA_W];
        assign we    = busy || bus.write_en[gi];

        always_ff @(posedge clk) begin
            if (we) mem[wr_row] <= busy ? '0 : wlane;
        end

        // Disabled lanes and busy cycles return zero; a same-cycle write to the read row wins.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_0_reg <= '0;
                rdata_1_reg <= '0;
            end else begin
                if (busy || !bus.read_en_0[gi])       rdata_0_reg <= '0;
                else if (bus.write_en[gi] && hit_0)   rdata_0_reg <= wlane;
                else                                  rdata_0_reg <= mem[rd_row_0];

                if (busy || !bus.read_en_1[gi])       rdata_1_reg <= '0;
                else if (bus.write_en[gi] && hit_1)   rdata_1_reg <= wlane;
                else                                  rdata_1_reg <= mem[rd_row_1];
            end
        end

        assign bus.rdata_0[gi*DATA_W +: DATA_W] = rdata_0_reg;
        assign bus.rdata_1[gi*DATA_W +: DATA_W] = rdata_1_reg;
    end
endmodule

// File: tb/tb_warp_regfile_param.sv
// Directed bench for warp_regfile_param: init sweep, walk, lane masking, forwarding, warp clear, reset mid-clear.
// Expected register contents come from a bench-side shadow of every row.
module tb_warp_regfile_param;
    localparam int LANES  = 16;
    localparam int WARPS  = 8;
    localparam int REGS   = 32;
    localparam int DATA_W = 64;
    localparam int W      = LANES * DATA_W;
    localparam int ROWS   = WARPS * REGS;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n;

    logic [W-1:0] model [ROWS];
    logic [W-1:0] exp_v;
    logic [W-1:0] data_v;

    warp_regfile_param_if #(.LANES(LANES), .WARPS(WARPS), .REGS(REGS), .DATA_W(DATA_W)) bus ();

    warp_regfile_param #(.LANES(LANES), .WARPS(WARPS), .REGS(REGS), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(int w, int r, int l);
        return {24'hC0FFEE, 8'(w), 8'(r), 8'(l), 16'h1357};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        int bad;
        bad = 0;
        for (int l = LANES - 1; l >= 0; l--)
            if (obs[l*DATA_W +: DATA_W] !== exp[l*DATA_W +: DATA_W]) bad = l;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s lane %0d: observed %h required %h", tag, bad,
                   obs[bad*DATA_W +: DATA_W], exp[bad*DATA_W +: DATA_W]);
        end
    endtask

    task automatic idle_inputs;
        bus.read_en_0  = '0;
        bus.raddr_0    = '0;
        bus.read_en_1  = '0;
        bus.raddr_1    = '0;
        bus.rwarp      = '0;
        bus.write_en   = '0;
        bus.waddr      = '0;
        bus.wwarp      = '0;
        bus.wdata      = '0;
        bus.clear_req  = 1'b0;
        bus.clear_warp = '0;
    endtask

    task automatic model_write(input int w, input int r, input logic [LANES-1:0] mask, input logic [W-1:0] d);
        for (int l = 0; l < LANES; l++)
            if (mask[l]) model[w*REGS + r][l*DATA_W +: DATA_W] = d[l*DATA_W +: DATA_W];
    endtask

    task automatic read_all(input string tag);
        for (int row = 0; row < ROWS; row++) begin
            bus.rwarp     = 3'(row / REGS);
            bus.raddr_0   = 5'(row % REGS);
            bus.raddr_1   = 5'(row % REGS);
            bus.read_en_0 = '1;
            bus.read_en_1 = '1;
            tick();
            chk({tag, "_p0"}, bus.rdata_0, model[row]);
            chk({tag, "_p1"}, bus.rdata_1, model[row]);
            chk({tag, "_rvalid"}, W'({bus.rvalid_1, bus.rvalid_0}), W'(2'b11));
        end
        idle_inputs();
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, W'(n), W'(ROWS));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < ROWS; i++) model[i] = '0;
        idle_inputs();

        // Reset state, then the INIT sweep length.
        rst_n = 1'b0;
        #12;
        chk("rst_busy", W'(bus.busy), W'(1'b1));
        chk("rst_rvalid", W'({bus.rvalid_1, bus.rvalid_0}), W'(2'b00));
        chk("rst_rdata_0", bus.rdata_0, '0);
        chk("rst_rdata_1", bus.rdata_1, '0);
        rst_n = 1'b1;
        count_busy("init_busy_cycles");
        read_all("init_zero");

        // Walk: write every row, read back on port 0, port 1, then both.
        for (int w = 0; w < WARPS; w++) begin
            for (int r = 0; r < REGS; r++) begin
                for (int l = 0; l < LANES; l++) data_v[l*DATA_W +: DATA_W] = pat(w, r, l);
                bus.wwarp    = 3'(w);
                bus.waddr    = 5'(r);
                bus.wdata    = data_v;
                bus.write_en = '1;
                tick();
                model_write(w, r, '1, data_v);
                bus.write_en  = '0;
                bus.rwarp     = 3'(w);
                bus.raddr_0   = 5'(r);
                bus.raddr_1   = 5'(r);
                bus.read_en_0 = '1;
                tick();
                chk("walk_p0", bus.rdata_0, model[w*REGS + r]);
                chk("walk_p0_valid", W'({bus.rvalid_1, bus.rvalid_0}), W'(2'b01));
                chk("walk_p0_other", bus.rdata_1, '0);
                bus.read_en_0 = '0;
                bus.read_en_1 = '1;
                tick();
                chk("walk_p1", bus.rdata_1, model[w*REGS + r]);
                chk("walk_p1_valid", W'({bus.rvalid_1, bus.rvalid_0}), W'(2'b10));
                bus.read_en_0 = '1;
                tick();
                chk("walk_both_p0", bus.rdata_0, model[w*REGS + r]);
                chk("walk_both_p1", bus.rdata_1, model[w*REGS + r]);
                chk("walk_both_valid", W'({bus.rvalid_1, bus.rvalid_0}), W'(2'b11));
                idle_inputs();
            end
        end

        // Per-lane write masking and per-lane read enables on w3 r5.
        bus.wwarp = 3'd3;
        bus.waddr = 5'd5;
        for (int l = 0; l < LANES; l++) data_v[l*DATA_W +: DATA_W] = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.wdata    = data_v;
        bus.write_en = 16'hFFFF;
        tick();
        model_write(3, 5, 16'hFFFF, data_v);
        for (int l = 0; l < LANES; l++) data_v[l*DATA_W +: DATA_W] = 64'h5555_5555_5555_5555;
        bus.wdata    = data_v;
        bus.write_en = 16'h00FF;
        tick();
        model_write(3, 5, 16'h00FF, data_v);
        bus.write_en  = '0;
        bus.rwarp     = 3'd3;
        bus.raddr_0   = 5'd5;
        bus.read_en_0 = 16'hFFFF;
        tick();
        for (int l = 0; l < LANES; l++)
            exp_v[l*DATA_W +: DATA_W] = (l < 8) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
        chk("mask_full", bus.rdata_0, exp_v);
        bus.read_en_0 = 16'h0F0F;
        tick();
        for (int l = 0; l < LANES; l++)
            if ((l % 8) >= 4) exp_v[l*DATA_W +: DATA_W] = '0;
        chk("mask_read_en", bus.rdata_0, exp_v);
        chk("mask_valid", W'(bus.rvalid_0), W'(1'b1));
        idle_inputs();

        // Forwarding: lane-0 write to w2 r7 seen in the same cycle; port 1 reads r6 unaffected.
        data_v = '1;
        data_v[DATA_W-1:0] = 64'h1234;
        bus.wwarp     = 3'd2;
        bus.waddr     = 5'd7;
        bus.wdata     = data_v;
        bus.write_en  = 16'h0001;
        bus.rwarp     = 3'd2;
        bus.raddr_0   = 5'd7;
        bus.raddr_1   = 5'd6;
        bus.read_en_0 = '1;
        bus.read_en_1 = '1;
        tick();
        model_write(2, 7, 16'h0001, data_v);
        chk("fwd_same_warp", bus.rdata_0, model[2*REGS + 7]);
        chk("fwd_other_reg", bus.rdata_1, model[2*REGS + 6]);
        data_v[DATA_W-1:0] = 64'h5678;
        bus.wdata = data_v;
        bus.rwarp = 3'd3;
        tick();
        model_write(2, 7, 16'h0001, data_v);
        chk("fwd_warp_mismatch", bus.rdata_0, model[3*REGS + 7]);
        bus.write_en = '0;
        bus.rwarp    = 3'd2;
        tick();
        chk("fwd_stored", bus.rdata_0, model[2*REGS + 7]);
        idle_inputs();

        // Warp clear with a same-cycle write to another warp, then writes and a second clear while busy.
        for (int l = 0; l < LANES; l++) data_v[l*DATA_W +: DATA_W] = 64'hFEED_0000_0000_0000 | 64'(l);
        bus.clear_req  = 1'b1;
        bus.clear_warp = 3'd4;
        bus.wwarp      = 3'd6;
        bus.waddr      = 5'd1;
        bus.wdata      = data_v;
        bus.write_en   = '1;
        tick();
        model_write(6, 1, '1, data_v);
        chk("clr_busy_start", W'(bus.busy), W'(1'b1));
        for (int k = 1; k <= REGS; k++) begin
            bus.clear_req  = (k == 5);
            bus.clear_warp = 3'd1;
            bus.write_en   = '1;
            bus.wwarp      = 3'd0;
            bus.waddr      = 5'd0;
            bus.wdata      = '1;
            bus.read_en_0  = '1;
            bus.rwarp      = 3'd0;
            tick();
            chk("clr_busy", W'(bus.busy), W'(k < REGS));
            chk("clr_rvalid", W'(bus.rvalid_0), W'(1'b0));
        end
        idle_inputs();
        for (int r = 0; r < REGS; r++) model[4*REGS + r] = '0;
        read_all("clr_after");

        // Reset ten cycles into a clear of warp 2.
        bus.clear_req  = 1'b1;
        bus.clear_warp = 3'd2;
        tick();
        idle_inputs();
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", W'(bus.busy), W'(1'b1));
        chk("midrst_rvalid", W'({bus.rvalid_1, bus.rvalid_0}), W'(2'b00));
        chk("midrst_rdata_0", bus.rdata_0, '0);
        chk("midrst_rdata_1", bus.rdata_1, '0);
        #10;
        rst_n = 1'b1;
        count_busy("midrst_busy_cycles");
        for (int i = 0; i < ROWS; i++) model[i] = '0;
        read_all("midrst_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
